multicycle_control_unit: RTL and testbench
==========================================

# multicycle_control_unit

Multi-cycle successor to the single-cycle RV32I `control_unit`. An FSM sequences each instruction through FETCH/DECODE/EXEC/MEM/WB, and handshakes with a variable-latency memory over `mem_ready`. It drives the same datapath selects as before, plus register-enable strobes for IR and PC. A parametrised watchdog traps when the memory does not respond.

## Interface
- `MEM_TIMEOUT`, default 15: maximum wait cycles in FETCH/MEM without `mem_ready`; 0 disables the watchdog.
- `clk` in 1: clock, rising edge.
- `rst` in 1: synchronous, active-high reset.
- `inst` in 32: instruction register contents; valid from DECODE onward.
- `zeros`, `flag_lt`, `flag_ltu` in 1 each: ALU flags, combinational, same cycle.
- `mem_ready` in 1: memory completes the current read/write this cycle.
- `alu_op_select` out 4: 0 ADD, 1 SUB, 2 SLL, 3 SLT, 4 SLTU, 5 XOR, 6 SRL, 7 SRA, 8 OR, 9 AND, 10 PASSB.
- `alu_scr_sel_1` out 1: 0 rs1, 1 PC.
- `alu_scr_sel_2` out 1: 0 rs2, 1 imm.
- `ir_write`, `pc_write`, `reg_write`, `mem_read`, `mem_write` out 1 each: strobes.
- `PC_select` out 2: 00 PC+4, 01 PC+imm, 10 rs1+imm.
- `write_from` out 2: 00 ALU, 01 memory, 10 PC+4.
- `state` out 3: 0 FETCH, 1 DECODE, 2 EXEC, 3 MEM, 4 WB, 5 TRAP.
- `trap` out 1: high in TRAP.
- `trap_cause` out 1: 0 timeout, 1 illegal instruction.

## Operation
- Outputs are combinational from the state register, `inst` and the flags. All strobes are 0 unless stated.
- **FETCH**
  - `mem_read`=1.
  - On `mem_ready`: `ir_write`=1, go to DECODE.
- **DECODE**
  - No strobes; one cycle.
  - Legal opcodes: 0110011, 0010011, 0000011, 0100011, 1100011, 1101111, 1100111, 0110111 (LUI), 0010111 (AUIPC).
  - Illegal opcode: see Configuration.
- **EXEC**
  - R-type: op from funct3 and funct7[5] (SUB, SRA); sel_1=0, sel_2=0; go to WB.
  - I-ALU: op from funct3, sel_2=1; SRAI is selected by inst[30]; go to WB.
  - LOAD/STORE: ADD, sel_2=1; go to MEM.
  - LUI: PASSB, sel_2=1; go to WB.
  - AUIPC: ADD, sel_1=1, sel_2=1; go to WB.
  - BRANCH: SUB with sel_1=0, sel_2=0.
    - Taken condition by funct3: 000 `zeros`, 001 !`zeros`, 100 `flag_lt`, 101 !`flag_lt`, 110 `flag_ltu`, 111 !`flag_ltu`.
    - `pc_write`=1; `PC_select`=01 if taken, else 00; go to FETCH.
    - funct3 010 or 011 is illegal.
  - JAL/JALR: go to WB.
- **MEM**
  - LOAD: `mem_read`=1. On `mem_ready`, go to WB.
  - STORE: `mem_write`=1. On `mem_ready`, `pc_write`=1, `PC_select`=00, go to FETCH.
- **WB**
  - `reg_write`=1, `pc_write`=1, then go to FETCH.
  - `write_from`: 01 for LOAD, 10 for JAL/JALR, else 00.
  - `PC_select`: 01 for JAL, 10 for JALR, else 00.
- **TRAP**
  - All strobes 0; `trap`=1.
  - Sticky; only `rst` exits.
- **Watchdog**
  - Counter is cleared on entry to FETCH or MEM and increments each cycle without `mem_ready`.
  - Counter width is $clog2(MEM_TIMEOUT+1).
  - When the count equals `MEM_TIMEOUT` with `mem_ready` low, go to TRAP with `trap_cause`=0. `mem_ready` in that same cycle wins.

## Timing
- Reset:
  - `state`=FETCH; counter=0; `trap`=0; `trap_cause`=0.
  - All strobes are forced 0 during any cycle with `rst` high.
- Cycle counts with `mem_ready` tied high:
  - ALU/LUI/AUIPC/JAL/JALR: 4 (F, D, E, W).
  - LOAD: 5.
  - STORE: 4.
  - BRANCH: 3.
- Each memory wait cycle adds 1.
- `mem_read`/`mem_write` are held constant until the `mem_ready` cycle and drop the cycle after.
- `pc_write` occurs exactly once per retired instruction; `ir_write` occurs once per fetch.
- `rst` mid-instruction: the next cycle is FETCH; no strobe fires in the reset cycle.

## Configuration
- `CTRL_ILLEGAL_TRAP_EN` defined:
  - Illegal opcode or branch funct3 in DECODE/EXEC goes to TRAP with `trap_cause`=1.
- Not defined:
  - Illegal instructions retire as NOP: DECODE, then one EXEC cycle with `pc_write`=1 and `PC_select`=00, then FETCH.
  - `trap_cause` is tied to 0.

## Test plan
- ADD x3,x1,x2 with `mem_ready`=1:
  - States 0,1,2,4.
  - EXEC `alu_op_select`=0; WB `reg_write`=1, `write_from`=00, `pc_write`=1.
- SUB (funct7=0100000) → `alu_op_select`=1. LOAD with `mem_ready` low 3 cycles:
  - `mem_read` high 4 cycles in MEM.
  - WB `write_from`=01; 8 cycles total.
- BEQ:
  - `zeros`=1 → EXEC `pc_write`=1, `PC_select`=01.
  - Repeat with `zeros`=0 → `PC_select`=00.
  - BLTU with `flag_ltu`=1 → taken.
- JALR:
  - WB `write_from`=10, `PC_select`=10, `reg_write`=1.
  - STORE: MEM `mem_write`=1, `reg_write` never asserted.
- `mem_ready` held 0 in FETCH with MEM_TIMEOUT=15:
  - `trap`=1, `trap_cause`=0 after 16 FETCH cycles.
  - `mem_ready` on the 16th cycle → no trap.
  - `rst` → `state`=0.
- Opcode 1111111:
  - With `CTRL_ILLEGAL_TRAP_EN` → `trap_cause`=1.
  - Without → NOP, `pc_write` in EXEC, back to FETCH.

Source files
------------

// File: rtl/multicycle_control_unit.sv
// rtl/multicycle_control_unit.sv - multi-cycle RV32I control FSM with memory handshake and watchdog
// Optional CTRL_ILLEGAL_TRAP_EN: illegal instructions trap instead of retiring as NOP.
module multicycle_control_unit #(
    parameter int MEM_TIMEOUT = 15
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [31:0] inst,
    input  logic        zeros,
    input  logic        flag_lt,
    input  logic        flag_ltu,
    input  logic        mem_ready,
    output logic [3:0]  alu_op_select,
    output logic        alu_scr_sel_1,
    output logic        alu_scr_sel_2,
    output logic        ir_write,
    output logic        pc_write,
    output logic        reg_write,
    output logic        mem_read,
    output logic        mem_write,
    output logic [1:0]  PC_select,
    output logic [1:0]  write_from,
    output logic [2:0]  state,
    output logic        trap,
    output logic        trap_cause
);
    localparam logic [2:0] S_FETCH  = 3'd0;
    localparam logic [2:0] S_DECODE = 3'd1;
    localparam logic [2:0] S_EXEC   = 3'd2;
    localparam logic [2:0] S_MEM    = 3'd3;
    localparam logic [2:0] S_WB     = 3'd4;
    localparam logic [2:0] S_TRAP   = 3'd5;

    localparam logic [6:0] OP_R     = 7'b0110011;
    localparam logic [6:0] OP_I     = 7'b0010011;
    localparam logic [6:0] OP_LOAD  = 7'b0000011;
    localparam logic [6:0] OP_STORE = 7'b0100011;
    localparam logic [6:0] OP_BR    = 7'b1100011;
    localparam logic [6:0] OP_JAL   = 7'b1101111;
    localparam logic [6:0] OP_JALR  = 7'b1100111;
    localparam logic [6:0] OP_LUI   = 7'b0110111;
    localparam logic [6:0] OP_AUIPC = 7'b0010111;

    // Width kept at least 1 so MEM_TIMEOUT=0 still elaborates.
    localparam int CW = (MEM_TIMEOUT > 0) ? $clog2(MEM_TIMEOUT + 1) : 1;

    logic [6:0]    opcode;
    logic [2:0]    funct3;
    logic          legal_op;
    logic          illegal;
    logic          taken;
    logic          wd_expire;
    logic [CW-1:0] wd_cnt;
    logic [2:0]    state_next;
    logic          cause_next;
    logic          ir_c, pc_c, reg_c, mrd_c, mwr_c;
    logic          unused_bits;

    assign opcode      = inst[6:0];
    assign funct3      = inst[14:12];
    assign unused_bits = ^{inst[31], inst[29:15], inst[11:7]};

    always_comb begin
        legal_op = 1'b0;
        case (opcode)
            OP_R, OP_I, OP_LOAD, OP_STORE, OP_BR,
            OP_JAL, OP_JALR, OP_LUI, OP_AUIPC: legal_op = 1'b1;
            default:                           legal_op = 1'b0;
        endcase
    end

    assign illegal   = !legal_op || (opcode == OP_BR && funct3[2:1] == 2'b01);
    assign wd_expire = (MEM_TIMEOUT != 0) && (wd_cnt == CW'(MEM_TIMEOUT)) && !mem_ready;

    always_comb begin
        case (funct3)
            3'b000:  taken = zeros;
            3'b001:  taken = !zeros;
            3'b100:  taken = flag_lt;
            3'b101:  taken = !flag_lt;
            3'b110:  taken = flag_ltu;
            3'b111:  taken = !flag_ltu;
            default: taken = 1'b0;
        endcase
    end

    function automatic logic [3:0] alu_from_funct3(input logic [2:0] f3, input logic alt);
        case (f3)
            3'b000:  alu_from_funct3 = alt ? 4'd1 : 4'd0;
            3'b001:  alu_from_funct3 = 4'd2;
            3'b010:  alu_from_funct3 = 4'd3;
            3'b011:  alu_from_funct3 = 4'd4;
            3'b100:  alu_from_funct3 = 4'd5;
            3'b101:  alu_from_funct3 = alt ? 4'd7 : 4'd6;
            3'b110:  alu_from_funct3 = 4'd8;
            default: alu_from_funct3 = 4'd9;
        endcase
    endfunction

    always_comb begin
        state_next    = state;
        cause_next    = trap_cause;
        alu_op_select = 4'd0;
        alu_scr_sel_1 = 1'b0;
        alu_scr_sel_2 = 1'b0;
        PC_select     = 2'b00;
        write_from    = 2'b00;
        ir_c  = 1'b0;
        pc_c  = 1'b0;
        reg_c = 1'b0;
        mrd_c = 1'b0;
        mwr_c = 1'b0;
        case (state)
            S_FETCH: begin
                mrd_c = 1'b1;
                if (mem_ready) begin
                    ir_c       = 1'b1;
                    state_next = S_DECODE;
                end else if (wd_expire) begin
                    state_next = S_TRAP;
                    cause_next = 1'b0;
                end
            end
            S_DECODE: begin
`ifdef CTRL_ILLEGAL_TRAP_EN
                if (illegal) begin
                    state_next = S_TRAP;
                    cause_next = 1'b1;
                end else begin
                    state_next = S_EXEC;
                end
`else
                state_next = S_EXEC;
`endif
            end
            S_EXEC: begin
                if (illegal) begin
`ifdef CTRL_ILLEGAL_TRAP_EN
                    state_next = S_TRAP;
                    cause_next = 1'b1;
`else
                    pc_c       = 1'b1;
                    state_next = S_FETCH;
`endif
                end else begin
                    case (opcode)
                        OP_R: begin
                            alu_op_select = alu_from_funct3(funct3, inst[30]);
                            state_next    = S_WB;
                        end
                        OP_I: begin
                            alu_op_select = alu_from_funct3(funct3, (funct3 == 3'b101) && inst[30]);
                            alu_scr_sel_2 = 1'b1;
                            state_next    = S_WB;
                        end
                        OP_LOAD, OP_STORE: begin
                            alu_scr_sel_2 = 1'b1;
                            state_next    = S_MEM;
                        end
                        OP_LUI: begin
                            alu_op_select = 4'd10;
                            alu_scr_sel_2 = 1'b1;
                            state_next    = S_WB;
                        end
                        OP_AUIPC: begin
                            alu_scr_sel_1 = 1'b1;
                            alu_scr_sel_2 = 1'b1;
                            state_next    = S_WB;
                        end
                        OP_BR: begin
                            alu_op_select = 4'd1;
                            pc_c          = 1'b1;
                            PC_select     = taken ? 2'b01 : 2'b00;
                            state_next    = S_FETCH;
                        end
                        default: state_next = S_WB;
                    endcase
                end
            end
            S_MEM: begin
                // Keep the address computation on the ALU while memory is busy.
                alu_scr_sel_2 = 1'b1;
                if (opcode == OP_LOAD) begin
                    mrd_c = 1'b1;
                    if (mem_ready) state_next = S_WB;
                end else begin
                    mwr_c = 1'b1;
                    if (mem_ready) begin
                        pc_c       = 1'b1;
                        state_next = S_FETCH;
                    end
                end
                if (!mem_ready && wd_expire) begin
                    state_next = S_TRAP;
                    cause_next = 1'b0;
                end
            end
            S_WB: begin
                reg_c      = 1'b1;
                pc_c       = 1'b1;
                write_from = (opcode == OP_LOAD) ? 2'b01 :
                             (opcode == OP_JAL || opcode == OP_JALR) ? 2'b10 : 2'b00;
                PC_select  = (opcode == OP_JAL) ? 2'b01 :
                             (opcode == OP_JALR) ? 2'b10 : 2'b00;
                state_next = S_FETCH;
            end
            S_TRAP:  state_next = S_TRAP;
            default: state_next = S_FETCH;
        endcase
    end

    assign ir_write  = ir_c  & ~rst;
    assign pc_write  = pc_c  & ~rst;
    assign reg_write = reg_c & ~rst;
    assign mem_read  = mrd_c & ~rst;
    assign mem_write = mwr_c & ~rst;
    assign trap      = (state == S_TRAP);

    always_ff @(posedge clk) begin
        if (rst) begin
            state  <= S_FETCH;
            wd_cnt <= '0;
        end else begin
            state <= state_next;
            if (state_next != state)
                wd_cnt <= '0;
            else if (!mem_ready && (state == S_FETCH || state == S_MEM))
                wd_cnt <= wd_cnt + CW'(1);
        end
    end

`ifdef CTRL_ILLEGAL_TRAP_EN
    logic cause_q;
    always_ff @(posedge clk) begin
        if (rst) cause_q <= 1'b0;
        else     cause_q <= cause_next;
    end
    assign trap_cause = cause_q;
`else
    logic unused_cause;
    assign unused_cause = cause_next;
    assign trap_cause   = 1'b0;
`endif
endmodule

// File: tb/tb_multicycle_control_unit.sv
// tb/tb_multicycle_control_unit.sv - scoreboard bench for multicycle_control_unit
module tb_multicycle_control_unit;
    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [31:0] inst = 32'h0;
    logic        zeros = 1'b0, flag_lt = 1'b0, flag_ltu = 1'b0, mem_ready = 1'b0;
    logic [3:0]  alu_op_select;
    logic        alu_scr_sel_1, alu_scr_sel_2;
    logic        ir_write, pc_write, reg_write, mem_read, mem_write;
    logic [1:0]  PC_select, write_from;
    logic [2:0]  state;
    logic        trap, trap_cause;

    multicycle_control_unit #(.MEM_TIMEOUT(15)) dut (
        .clk(clk), .rst(rst), .inst(inst), .zeros(zeros), .flag_lt(flag_lt),
        .flag_ltu(flag_ltu), .mem_ready(mem_ready), .alu_op_select(alu_op_select),
        .alu_scr_sel_1(alu_scr_sel_1), .alu_scr_sel_2(alu_scr_sel_2),
        .ir_write(ir_write), .pc_write(pc_write), .reg_write(reg_write),
        .mem_read(mem_read), .mem_write(mem_write), .PC_select(PC_select),
        .write_from(write_from), .state(state), .trap(trap), .trap_cause(trap_cause)
    );

    always #5 clk = ~clk;

    localparam logic [2:0] SF = 3'd0, SD = 3'd1, SE = 3'd2, SM = 3'd3, SW = 3'd4, ST = 3'd5;
    // strobe order {ir, pc, reg, mem_read, mem_write}
    localparam logic [4:0] B0 = 5'b00000, B_F = 5'b00010, B_FI = 5'b10010, B_PC = 5'b01000,
                           B_WB = 5'b01100, B_SW = 5'b01001;
    localparam logic [19:0] MB = 20'hFFC00, MSTB = 20'h07C00;
    localparam logic [19:0] MA = MB | 20'h003F0, MP = MB | 20'h0000C, MW = MB | 20'h0000F;

    localparam logic [31:0] I_ADD   = 32'h002081B3, I_SUB = 32'h402081B3;
    localparam logic [31:0] I_SRAI  = 32'h4030D093, I_LW  = 32'h0000A283;
    localparam logic [31:0] I_SW    = 32'h0050A023, I_BEQ = 32'h00208063;
    localparam logic [31:0] I_BLTU  = 32'h0020E063, I_JALR = 32'h000100E7;
    localparam logic [31:0] I_ILL   = 32'h0000007F;

    typedef struct {
        logic [19:0] e;
        logic [19:0] m;
        string       nm;
    } exp_t;

    exp_t q[$];
    exp_t x;
    int   n_cmp = 0;
    int   n_err = 0;
    logic [19:0] act;

    function automatic logic [19:0] ev(input logic [2:0] st, input logic tr, input logic ca,
                                       input logic [4:0] sb, input logic [3:0] alu,
                                       input logic s1, input logic s2,
                                       input logic [1:0] pcs, input logic [1:0] wf);
        ev = {st, tr, ca, sb, alu, s1, s2, pcs, wf};
    endfunction

    always @(negedge clk) begin
        if (q.size() > 0) begin
            x   = q.pop_front();
            act = {state, trap, trap_cause, ir_write, pc_write, reg_write, mem_read, mem_write,
                   alu_op_select, alu_scr_sel_1, alu_scr_sel_2, PC_select, write_from};
            n_cmp++;
            if ((act & x.m) !== (x.e & x.m)) begin
                n_err++;
                $display("FAIL %s: got %h required %h (mask %h)", x.nm, act & x.m, x.e & x.m, x.m);
            end
        end
    end

    task automatic cyc(input string nm, input logic [31:0] i, input logic r, input logic rd,
                       input logic z, input logic lt, input logic ltu,
                       input logic [19:0] e, input logic [19:0] m);
        exp_t t;
        @(posedge clk);
        #1;
        rst = r; inst = i; mem_ready = rd; zeros = z; flag_lt = lt; flag_ltu = ltu;
        t.e = e; t.m = m; t.nm = nm;
        q.push_back(t);
    endtask

    task automatic c(input string nm, input logic [31:0] i, input logic rd,
                     input logic [19:0] e, input logic [19:0] m);
        cyc(nm, i, 1'b0, rd, 1'b0, 1'b0, 1'b0, e, m);
    endtask

    task automatic fd(input string nm, input logic [31:0] i);
        c({nm, "_F"}, i, 1'b1, ev(SF, 0, 0, B_FI, 0, 0, 0, 0, 0), MB);
        c({nm, "_D"}, i, 1'b1, ev(SD, 0, 0, B0, 0, 0, 0, 0, 0), MB);
    endtask

    initial begin
        cyc("rst_a", I_ADD, 1, 0, 0, 0, 0, ev(SF, 0, 0, B0, 0, 0, 0, 0, 0), MSTB);
        cyc("rst_b", I_ADD, 1, 1, 0, 0, 0, ev(SF, 0, 0, B0, 0, 0, 0, 0, 0), MSTB);
        c("reset_state", I_ADD, 0, ev(SF, 0, 0, B_F, 0, 0, 0, 0, 0), MB);

        fd("add", I_ADD);
        c("add_E", I_ADD, 1, ev(SE, 0, 0, B0, 4'd0, 0, 0, 0, 0), MA);
        c("add_W", I_ADD, 1, ev(SW, 0, 0, B_WB, 0, 0, 0, 2'b00, 2'b00), MW);

        fd("sub", I_SUB);
        c("sub_E", I_SUB, 1, ev(SE, 0, 0, B0, 4'd1, 0, 0, 0, 0), MA);
        c("sub_W", I_SUB, 1, ev(SW, 0, 0, B_WB, 0, 0, 0, 0, 0), MW);

        fd("srai", I_SRAI);
        c("srai_E", I_SRAI, 1, ev(SE, 0, 0, B0, 4'd7, 0, 1, 0, 0), MA);
        c("srai_W", I_SRAI, 1, ev(SW, 0, 0, B_WB, 0, 0, 0, 0, 0), MW);

        fd("lw", I_LW);
        c("lw_E", I_LW, 1, ev(SE, 0, 0, B0, 4'd0, 0, 1, 0, 0), MA);
        for (int k = 0; k < 3; k++)
            c("lw_Mwait", I_LW, 0, ev(SM, 0, 0, B_F, 0, 0, 0, 0, 0), MB);
        c("lw_Mrdy", I_LW, 1, ev(SM, 0, 0, B_F, 0, 0, 0, 0, 0), MB);
        c("lw_W", I_LW, 1, ev(SW, 0, 0, B_WB, 0, 0, 0, 2'b00, 2'b01), MW);

        fd("beq_t", I_BEQ);
        cyc("beq_t_E", I_BEQ, 0, 1, 1, 0, 0, ev(SE, 0, 0, B_PC, 4'd1, 0, 0, 2'b01, 0), MA | MP);
        fd("beq_n", I_BEQ);
        cyc("beq_n_E", I_BEQ, 0, 1, 0, 0, 0, ev(SE, 0, 0, B_PC, 4'd1, 0, 0, 2'b00, 0), MA | MP);
        fd("bltu", I_BLTU);
        cyc("bltu_E", I_BLTU, 0, 1, 0, 0, 1, ev(SE, 0, 0, B_PC, 4'd1, 0, 0, 2'b01, 0), MA | MP);

        fd("jalr", I_JALR);
        c("jalr_E", I_JALR, 1, ev(SE, 0, 0, B0, 0, 0, 0, 0, 0), MB);
        c("jalr_W", I_JALR, 1, ev(SW, 0, 0, B_WB, 0, 0, 0, 2'b10, 2'b10), MW);

        fd("sw", I_SW);
        c("sw_E", I_SW, 1, ev(SE, 0, 0, B0, 4'd0, 0, 1, 0, 0), MA);
        c("sw_M", I_SW, 1, ev(SM, 0, 0, B_SW, 0, 0, 0, 2'b00, 0), MP);

        fd("ill", I_ILL);
`ifdef CTRL_ILLEGAL_TRAP_EN
        c("ill_trap", I_ILL, 1, ev(ST, 1, 1, B0, 0, 0, 0, 0, 0), MB);
        c("ill_sticky", I_ILL, 1, ev(ST, 1, 1, B0, 0, 0, 0, 0, 0), MB);
`else
        c("ill_nop_E", I_ILL, 1, ev(SE, 0, 0, B_PC, 0, 0, 0, 2'b00, 0), MP);
        c("ill_back_F", I_ADD, 0, ev(SF, 0, 0, B_F, 0, 0, 0, 0, 0), MB);
`endif
        cyc("ill_rst", I_ADD, 1, 1, 0, 0, 0, ev(SF, 0, 0, B0, 0, 0, 0, 0, 0), MSTB);

        for (int k = 0; k < 15; k++)
            c("wd_wait", I_ADD, 0, ev(SF, 0, 0, B_F, 0, 0, 0, 0, 0), MB);
        c("wd_rdy16", I_ADD, 1, ev(SF, 0, 0, B_FI, 0, 0, 0, 0, 0), MB);
        c("wd_D", I_ADD, 1, ev(SD, 0, 0, B0, 0, 0, 0, 0, 0), MB);
        cyc("mid_rst", I_ADD, 1, 1, 0, 0, 0, ev(SE, 0, 0, B0, 0, 0, 0, 0, 0), MSTB);
        c("mid_rst_F", I_ADD, 0, ev(SF, 0, 0, B_F, 0, 0, 0, 0, 0), MB);

        for (int k = 0; k < 15; k++)
            c("wd_wait2", I_ADD, 0, ev(SF, 0, 0, B_F, 0, 0, 0, 0, 0), MB);
        c("wd_trap", I_ADD, 0, ev(ST, 1, 0, B0, 0, 0, 0, 0, 0), MB);
        c("wd_sticky", I_ADD, 1, ev(ST, 1, 0, B0, 0, 0, 0, 0, 0), MB);
        cyc("wd_rst", I_ADD, 1, 1, 0, 0, 0, ev(ST, 0, 0, B0, 0, 0, 0, 0, 0), MSTB);
        c("wd_after_rst", I_ADD, 0, ev(SF, 0, 0, B_F, 0, 0, 0, 0, 0), MB);

        for (int k = 0; k < 20 && q.size() > 0; k++) @(posedge clk);
        if (q.size() != 0) begin
            n_cmp++;
            n_err++;
            $display("FAIL drain: %0d pending required 0", q.size());
        end
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
